// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: four-digit multiplexed seven-segment driver with dead time between digits
// and frame-synchronous double buffering of the displayed data.
module seg7_scan_driver #(
   parameter int DEAD_CYCLES = 4,
   parameter int DEAD_WIDTH  = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        tick_i,
   input  logic        load_i,
   input  logic [15:0] value_i,
   input  logic [3:0]  dp_i,
   input  logic [3:0]  blank_i,
   output logic [6:0]  seg_o,
   output logic        dp_o,
   output logic [3:0]  sel_o,
   output logic [1:0]  digit_idx_o,
   output logic        frame_done_o
);
   typedef enum logic {DEAD, SHOW} state_e;
   state_e                state_q, state_d;
   logic [DEAD_WIDTH-1:0] cnt_q, cnt_d;
   logic [1:0]            idx_q, idx_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [15:0]           pend_val_q, pend_val_d, disp_val_q, disp_val_d;
   logic [3:0]            pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
   logic [3:0]            pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [3:0]            sel_q, sel_d;
   logic                  frame_done_q, frame_done_d;
   logic                  boundary, transfer, show_d;
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'b1000000;
         4'h1: hex7 = 7'b1111001;
         4'h2: hex7 = 7'b0100100;
         4'h3: hex7 = 7'b0110000;
         4'h4: hex7 = 7'b0011001;
         4'h5: hex7 = 7'b0010010;
         4'h6: hex7 = 7'b0000010;
         4'h7: hex7 = 7'b1111000;
         4'h8: hex7 = 7'b0000000;
         4'h9: hex7 = 7'b0010000;
         4'hA: hex7 = 7'b0001000;
         4'hB: hex7 = 7'b0000011;
         4'hC: hex7 = 7'b1000110;
         4'hD: hex7 = 7'b0100001;
         4'hE: hex7 = 7'b0000110;
         default: hex7 = 7'b0001110;
      endcase
   endfunction
   // Outputs are registered from next-state values so they change in step with the FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      boundary     = state_q == SHOW && tick_i && idx_q == 2'd3;
      transfer     = boundary && pend_valid_q;
      if (state_q == DEAD) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == DEAD_WIDTH'(DEAD_CYCLES - 1)) begin
            state_d = SHOW;
            cnt_d   = '0;
         end
      end else if (tick_i) begin
         state_d = DEAD;
         idx_d   = idx_q + 1'b1;
      end
      pend_val_d   = load_i ? value_i : pend_val_q;
      pend_dp_d    = load_i ? dp_i : pend_dp_q;
      pend_blank_d = load_i ? blank_i : pend_blank_q;
      pend_valid_d = load_i | (pend_valid_q & ~boundary);
      disp_val_d   = transfer ? pend_val_q : disp_val_q;
      disp_dp_d    = transfer ? pend_dp_q : disp_dp_q;
      disp_blank_d = transfer ? pend_blank_q : disp_blank_q;
      show_d       = state_d == SHOW;
      sel_d        = show_d && !disp_blank_d[idx_d] ? ~(4'b0001 << idx_d) : 4'b1111;
      seg_d        = show_d ? hex7(disp_val_d[{idx_d, 2'b00} +: 4]) : 7'b1111111;
      dp_d         = !(show_d && disp_dp_d[idx_d]);
      frame_done_d = boundary;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= DEAD;
         cnt_q        <= '0;
         idx_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_val_q   <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= 4'b1111;
         disp_val_q   <= '0;
         disp_dp_q    <= '0;
         disp_blank_q <= 4'b1111;
         seg_q        <= 7'b1111111;
         dp_q         <= 1'b1;
         sel_q        <= 4'b1111;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         pend_valid_q <= pend_valid_d;
         pend_val_q   <= pend_val_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         disp_val_q   <= disp_val_d;
         disp_dp_q    <= disp_dp_d;
         disp_blank_q <= disp_blank_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         sel_q        <= sel_d;
         frame_done_q <= frame_done_d;
      end
   end
   assign seg_o        = seg_q;
   assign dp_o         = dp_q;
   assign sel_o        = sel_q;
   assign digit_idx_o  = idx_q;
   assign frame_done_o = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, dead time, decode and frame-boundary buffering.
module tb_seg7_scan_driver;
   logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0, blank_in = '0;
   logic [6:0]  seg;
   logic        dp_out, fd, fd_seen, mon_en = 1'b0;
   logic [3:0]  sel;
   logic [1:0]  idx;
   int          n_chk = 0, n_fail = 0, sel_bad = 0, fd_cnt = 0, dead = 0;
   always #5 clk = ~clk;
   seg7_scan_driver #(.DEAD_CYCLES(4), .DEAD_WIDTH(3)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tick_i(tick), .load_i(load), .value_i(value),
      .dp_i(dp_in), .blank_i(blank_in), .seg_o(seg), .dp_o(dp_out), .sel_o(sel),
      .digit_idx_o(idx), .frame_done_o(fd)
   );
   always @(negedge clk) begin
      if (mon_en) begin
         if (sel != 4'hF) sel_bad <= sel_bad + 1;
         if (fd) fd_cnt <= fd_cnt + 1;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic clocks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic advance();
      tick = 1'b1;
      clocks(1);
      tick = 1'b0;
      load = 1'b0;
      fd_seen = fd;
      clocks(4);
   endtask
   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v;
      dp_in = d;
      blank_in = b;
      load = 1'b1;
      clocks(1);
      load = 1'b0;
   endtask
   task automatic digit(input string tag, input logic [3:0] s, input logic [6:0] g, input logic p);
      check({tag, "_sel"}, 32'(sel), 32'(s));
      check({tag, "_seg"}, 32'(seg), 32'(g));
      check({tag, "_dp"}, 32'(dp_out), 32'(p));
   endtask
   initial begin
      clocks(3);
      digit("rst", 4'hF, 7'h7F, 1'b1);
      check("rst_idx", 32'(idx), 0);
      check("rst_fd", 32'(fd), 0);
      rst_n = 1'b1;
      mon_en = 1'b1;
      repeat (50) begin
         clocks(9);
         tick = 1'b1;
         clocks(1);
         tick = 1'b0;
      end
      mon_en = 1'b0;
      #2;
      check("noload_sel_bad", 32'(sel_bad), 0);
      check("noload_fd_cnt", 32'(fd_cnt), 12);
      check("noload_idx", 32'(idx), 2);
      clocks(4);
      do_load(16'h1A80, 4'b0010, 4'b0000);
      advance();
      check("pre_frame_d3_sel", 32'(sel), 32'hF);
      advance();
      check("frame_fd", 32'(fd_seen), 1);
      check("frame_idx0", 32'(idx), 0);
      digit("ld_d0", 4'hE, 7'b1000000, 1'b1);
      advance();
      digit("ld_d1", 4'hD, 7'b0000000, 1'b0);
      advance();
      digit("ld_d2", 4'hB, 7'b0001000, 1'b1);
      advance();
      digit("ld_d3", 4'h7, 7'b1111001, 1'b1);
      tick = 1'b1;
      clocks(1);
      tick = 1'b0;
      check("dead_fd_hi", 32'(fd), 1);
      dead = 0;
      while (sel == 4'hF && dead < 10) begin
         dead++;
         tick = (dead == 2);
         clocks(1);
      end
      tick = 1'b0;
      check("dead_cycles", 32'(dead), 4);
      check("dead_idx", 32'(idx), 0);
      check("dead_fd_lo", 32'(fd), 0);
      check("dead_next_sel", 32'(sel), 32'hE);
      do_load(16'h1111, 4'b0000, 4'b0000);
      advance();
      advance();
      advance();
      check("mid_frame_old_seg", 32'(seg), 32'(7'b1111001));
      value = 16'h2222;
      load = 1'b1;
      advance();
      check("dbl_fd", 32'(fd_seen), 1);
      digit("dbl_f1_d0", 4'hE, 7'b1111001, 1'b1);
      advance();
      advance();
      advance();
      digit("dbl_f1_d3", 4'h7, 7'b1111001, 1'b1);
      advance();
      digit("dbl_f2_d0", 4'hE, 7'b0100100, 1'b1);
      do_load(16'h4321, 4'b0000, 4'b0100);
      advance();
      advance();
      advance();
      check("blk_pre_d3_seg", 32'(seg), 32'(7'b0100100));
      advance();
      digit("blk_d0", 4'hE, 7'b1111001, 1'b1);
      advance();
      digit("blk_d1", 4'hD, 7'b0100100, 1'b1);
      advance();
      check("blk_d2_sel", 32'(sel), 32'hF);
      advance();
      digit("blk_d3", 4'h7, 7'b0011001, 1'b1);
      advance();
      advance();
      advance();
      check("rst_pre_seg", 32'(seg), 32'(7'b0110000));
      do_load(16'h8888, 4'b1111, 4'b0000);
      #3 rst_n = 1'b0;
      #1;
      digit("arst", 4'hF, 7'h7F, 1'b1);
      check("arst_idx", 32'(idx), 0);
      clocks(2);
      rst_n = 1'b1;
      clocks(4);
      check("post_rst_idx", 32'(idx), 0);
      check("post_rst_d0_seg", 32'(seg), 32'(7'b1000000));
      check("post_rst_d0_sel", 32'(sel), 32'hF);
      for (int i = 1; i <= 4; i++) begin
         advance();
         check($sformatf("post_rst_sel%0d", i), 32'(sel), 32'hF);
      end
      check("post_rst_dp", 32'(dp_out), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DEAD_CYCLES, default 4, meaning the number of all-digits-off clocks inserted between digits; legal range 1..7.
REQ-002 SHALL have parameter DEAD_WIDTH, default 3, meaning the width of the dead-time counter; it SHALL hold DEAD_CYCLES-1.
REQ-003 CLK  input  1  the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset.
REQ-005 TICK  input  1  single-cycle scan strobe from the upstream refresh counter's trigger output.
REQ-006 LOAD  input  1  single-cycle strobe that captures VALUE, DP_IN and BLANK_IN.
REQ-007 VALUE  input  16  four hex nibbles; digit n = VALUE[4n+3:4n].
REQ-008 DP_IN  input  4  decimal-point request per digit, active-high.
REQ-009 BLANK_IN  input  4  per-digit blank request, active-high.
REQ-010 SEG_OUT  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-011 DP_OUT  output  1  decimal point, active-low.
REQ-012 SEL_OUT  output  4  digit anodes, active-low; bit n drives digit n.
REQ-013 DIGIT_IDX  output  2  index of the current or next digit.
REQ-014 FRAME_DONE  output  1  one-cycle pulse at the end of a full 4-digit scan.

Function
REQ-015 Outputs SHALL be driven only from registered state, with no combinational path from any input to any output.
REQ-016 A LOAD SHALL write the pending registers (value, dp, blank) and set pending_valid; a LOAD while pending_valid=1 SHALL overwrite the pending data.
REQ-017 The FSM SHALL have two states: DEAD and SHOW.
REQ-018 In DEAD: SEL_OUT=4'b1111, SEG_OUT=7'b1111111, DP_OUT=1, and the dead counter increments each clock.
REQ-019 In DEAD, when the dead counter equals DEAD_CYCLES-1, the FSM SHALL move to SHOW and the counter SHALL clear.
REQ-020 TICK during DEAD SHALL be ignored and not queued.
REQ-021 In SHOW: SEL_OUT[DIGIT_IDX]=0 unless display blank[DIGIT_IDX]=1, in which case SEL_OUT=4'b1111; all other SEL_OUT bits =1.
REQ-022 In SHOW: SEG_OUT SHALL be the hex decode of the selected nibble, and DP_OUT SHALL be the inverse of display dp[DIGIT_IDX].
REQ-023 The hex decode SHALL produce: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110 (standard 16-entry table).
REQ-024 On TICK in SHOW: DIGIT_IDX SHALL increment modulo 4 (3 wraps to 0), the FSM SHALL enter DEAD, and outputs SHALL blank on the next clock.
REQ-025 On TICK in SHOW with DIGIT_IDX=3: FRAME_DONE=1 for exactly one cycle.
REQ-026 On TICK in SHOW with DIGIT_IDX=3 and pending_valid=1: the pending registers SHALL be copied to the display registers and pending_valid SHALL clear, so no frame ever mixes old and new data.
REQ-027 If LOAD coincides with a frame-boundary transfer: the transfer SHALL use the pre-existing pending data, and the LOAD data SHALL become the new pending data with pending_valid=1.
REQ-028 If LOAD coincides with a frame-boundary transfer and pending_valid=0: the transfer SHALL not occur, and the LOAD data SHALL be pending for the next boundary.
REQ-029 Display registers SHALL never change except at a frame boundary.

Reset
REQ-030 While RESET=0, state SHALL be forced to DEAD, with dead counter=0, DIGIT_IDX=0, pending_valid=0, and pending and display value/dp=0.
REQ-031 While RESET=0, pending and display blank SHALL be 4'b1111, with SEL_OUT=4'b1111, SEG_OUT=7'b1111111, DP_OUT=1 and FRAME_DONE=0.
REQ-032 Reset SHALL take effect immediately regardless of CLK.
REQ-033 After RESET rises, the block SHALL spend DEAD_CYCLES clocks in DEAD, then SHOW digit 0 (blanked until the first transfer).
REQ-034 Reset asserted mid-SHOW or mid-DEAD SHALL discard all pending data and scan position.

Verification
REQ-035 Reset release, no LOAD, TICK every 10 clocks for 50 ticks -> SEL_OUT stays 4'b1111 throughout; FRAME_DONE pulses every 4th tick.
REQ-036 LOAD VALUE=16'h1A80, DP_IN=4'b0010, BLANK_IN=0, then scan -> after the first FRAME_DONE, digit 0 shows 1000000 and digit 1 shows 0000000 with DP_OUT=0; digit 2 shows 0001000 and digit 3 shows 1111001.
REQ-037 Dead-time check, DEAD_CYCLES=4 -> after each TICK, exactly 4 clocks of SEL_OUT=4'b1111 before the next anode goes low; a TICK issued inside DEAD does not advance DIGIT_IDX.
REQ-038 LOAD 16'h1111 mid-frame, then LOAD 16'h2222 on the same cycle as the idx-3 TICK -> the next frame shows 1111 and the following frame shows 2222.
REQ-039 BLANK_IN=4'b0100 -> SEL_OUT=4'b1111 during digit 2 SHOW; the other digits light normally.
REQ-040 RESET pulsed low mid-SHOW of digit 2 with pending data -> outputs are off immediately, DIGIT_IDX=0, and the pending data is not displayed afterwards.
